xsleena_rom_loader: RTL and testbench
=====================================

Name: xsleena_rom_loader

Overview:
- Writer side of the per-ROM BRAM load port (bram_wr/bram_data/bram_addr/bram_cs) consumed by the tilemap, sprite and sound blocks.
- Takes the MiSTer ioctl download byte stream and decodes the linear download address into one of NUM_REGIONS ROM regions.
- Issues a one-hot chip select and a held write strobe to the matching region, and back-pressures the HPS with ioctl_wait.
- Raises rom_loaded once a download of the selected index completes.

Parameters:
- NUM_REGIONS, 8, number of ROM regions; width of bram_cs.
- REGION_BASE, packed NUM_REGIONS x 25 bits, region i start address in download space; entry i at bits [25*i +: 25].
- REGION_LOG2, packed NUM_REGIONS x 5 bits, log2 of region i size in bytes; maximum 20.
- ROM_INDEX, 8'd0, ioctl_index value that this loader accepts.
- WR_HOLD, 2, number of clk cycles bram_wr and bram_cs are held per byte; minimum 1.

Ports:
- clk  in  1  master clock
- RESETn  in  1  asynchronous active-low reset
- ioctl_download  in  1  download session active
- ioctl_index  in  8  download target index
- ioctl_wr  in  1  single-cycle byte strobe
- ioctl_addr  in  25  linear byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  busy; HPS must hold the next byte
- bram_wr  out  1  write strobe to region BRAMs
- bram_data  out  8  write data
- bram_addr  out  20  region-relative byte address
- bram_cs  out  NUM_REGIONS  one-hot region select
- rom_loaded  out  1  sticky; a complete accepted download has finished
- overrun  out  1  sticky; an ioctl_wr arrived while busy

Behaviour:
- Reset (async assert, sync deassert on clk): all outputs are 0. FSM enters IDLE. Internal hold counter and byte counter are cleared.
- Reset during WRITE: bram_wr and bram_cs drop immediately, so no partial strobe. The byte in flight is lost.
- Session: active when ioctl_download=1 and ioctl_index==ROM_INDEX. While no session is active, ioctl_wr is ignored.
- FSM states: IDLE, LATCH, DECODE, WRITE, DONE.
- IDLE -> LATCH: on ioctl_wr during an active session. ioctl_addr and ioctl_dout are registered in that cycle, and ioctl_wait goes to 1 from the next cycle.
- LATCH -> DECODE: one cycle, always. The hit vector is computed as: hit[i] = (addr >= BASE[i]) && (addr < BASE[i] + 2^LOG2[i]).
- Region overlap: lowest index wins.
- DECODE with a hit: bram_addr = (addr - BASE[i]) truncated to 20 bits, bram_data = latched byte, bram_cs = one-hot i, bram_wr = 1; go to WRITE.
- DECODE with no hit: byte is discarded, no strobe; return to IDLE.
- WRITE: bram_wr and bram_cs are held for exactly WR_HOLD cycles, then both go to 0 together. bram_addr and bram_data are stable for the whole hold. Then go to IDLE.
- ioctl_wait: 1 in LATCH, DECODE and WRITE; 0 in IDLE and DONE.
- Latency: ioctl_wr to first bram_wr cycle is 2 cycles. Per-byte occupancy is 2 + WR_HOLD cycles.
- ioctl_wr while busy: the byte is dropped and overrun is set. overrun clears only on reset or at the start of a new session.
- ioctl_download falling:
  - from IDLE: go to DONE immediately;
  - in LATCH, DECODE or WRITE: finish the byte in flight first, then go to DONE.
- DONE: rom_loaded = 1 if at least one byte hit a region during the session. Stay in DONE until ioctl_download rises again.
- New session entering from DONE: clear rom_loaded and overrun, go to IDLE.
- Address wrap: an ioctl_addr above the highest region never wraps into a region; it is discarded.

Optional Feature:
- Macro: XSLEENA_ROM_LOADER_CHECKSUM_EN.
- When defined, adds output port checksum [15:0]:
  - a running modulo-2^16 sum of every byte written to a BRAM;
  - cleared at session start and held after DONE;
  - discarded bytes are not summed.
- When undefined, the port and adder do not exist and behaviour is otherwise identical.

Test Plan:
- Setup for all tests: REGION_BASE {0x08000 for region 1, 0x00000 for region 0}, REGION_LOG2 {15, 15}, WR_HOLD=2.
- Single byte: ioctl_wr with addr 0x08010, dout 0xA5 -> 2 cycles later bram_cs=0b10, bram_addr=0x0010, bram_data=0xA5, bram_wr high for 2 cycles; ioctl_wait high for 4 cycles.
- Unmapped byte: addr 0x10000 -> no bram_wr, bram_cs stays 0, FSM back in IDLE after 2 cycles.
- Overrun and completion: second ioctl_wr one cycle after the first -> overrun=1, only the first byte is written. Then drop ioctl_download -> rom_loaded=1.
- Index filter: ioctl_index=1 with ROM_INDEX=0, stream 16 bytes -> no writes, ioctl_wait stays 0, rom_loaded stays 0.
- Async reset mid-WRITE: assert RESETn=0 in the first WRITE cycle -> bram_wr, bram_cs and ioctl_wait are 0 without a clock edge.
- Checksum (macro defined): bytes 0xFF, 0x01, 0x10 to region 0 -> checksum=0x0110.

Source files
------------

// File: rtl/xsleena_rom_loader.sv
// ioctl download writer: decodes the linear download address into ROM regions and strobes the region BRAMs.
// Optional XSLEENA_ROM_LOADER_CHECKSUM_EN adds a 16-bit running sum of written bytes.
module xsleena_rom_loader #(
    parameter int                          NUM_REGIONS = 8,
    parameter logic [NUM_REGIONS*25-1:0]   REGION_BASE = {25'h00E0000, 25'h00C0000, 25'h00A0000, 25'h0080000,
                                                          25'h0060000, 25'h0040000, 25'h0020000, 25'h0000000},
    parameter logic [NUM_REGIONS*5-1:0]    REGION_LOG2 = {8{5'd17}},
    parameter logic [7:0]                  ROM_INDEX   = 8'd0,
    parameter int                          WR_HOLD     = 2
) (
    input  logic                   clk,
    input  logic                   RESETn,
    input  logic                   ioctl_download,
    input  logic [7:0]             ioctl_index,
    input  logic                   ioctl_wr,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    output logic                   ioctl_wait,
    output logic                   bram_wr,
    output logic [7:0]             bram_data,
    output logic [19:0]            bram_addr,
    output logic [NUM_REGIONS-1:0] bram_cs,
    output logic                   rom_loaded,
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
    output logic [15:0]            checksum,
`endif
    output logic                   overrun
);

    // Handshake: a byte is taken on ioctl_wr only in IDLE of an active session;
    // ioctl_wait is high from the following cycle until the byte is fully written.
    typedef enum logic [2:0] {IDLE, LATCH, DECODE, WRITE, DONE} state_t;

    state_t state, state_d;

    logic                   session;
    logic                   busy;
    logic [24:0]            addr_q;
    logic [7:0]             data_q;
    logic                   hit_q;
    logic [7:0]             hold_cnt;
    logic [25:0]            byte_cnt;

    logic [NUM_REGIONS-1:0] hit_vec;
    logic [NUM_REGIONS-1:0] sel_oh;
    logic [19:0]            sel_off;
    logic                   any_hit;

    assign session    = ioctl_download && (ioctl_index == ROM_INDEX);
    assign busy       = (state == LATCH) || (state == DECODE) || (state == WRITE);
    assign ioctl_wait = busy;

    // 26-bit compare keeps base + size from wrapping past the top of download space.
    always_comb begin
        logic [25:0] base_i;
        logic [25:0] lim_i;
        logic [24:0] diff_i;
        base_i  = '0;
        lim_i   = '0;
        diff_i  = '0;
        hit_vec = '0;
        sel_oh  = '0;
        sel_off = '0;
        any_hit = 1'b0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            base_i     = {1'b0, REGION_BASE[25*i +: 25]};
            lim_i      = base_i + (26'd1 << REGION_LOG2[5*i +: 5]);
            hit_vec[i] = ({1'b0, addr_q} >= base_i) && ({1'b0, addr_q} < lim_i);
        end
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
                diff_i    = addr_q - REGION_BASE[25*i +: 25];
                sel_off   = diff_i[19:0];
                any_hit   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (!ioctl_download)          state_d = DONE;
                else if (session && ioctl_wr) state_d = LATCH;
            end
            LATCH:  state_d = DECODE;
            DECODE: begin
                if (hit_q)                    state_d = WRITE;
                else                          state_d = ioctl_download ? IDLE : DONE;
            end
            // WRITE spans WR_HOLD cycles: it exits on the first cycle after the strobe dropped.
            WRITE: begin
                if (!bram_wr)                 state_d = ioctl_download ? IDLE : DONE;
            end
            DONE: begin
                if (session)                  state_d = IDLE;
            end
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            addr_q     <= '0;
            data_q     <= '0;
            hit_q      <= 1'b0;
            hold_cnt   <= '0;
            byte_cnt   <= '0;
            bram_wr    <= 1'b0;
            bram_cs    <= '0;
            bram_addr  <= '0;
            bram_data  <= '0;
            rom_loaded <= 1'b0;
            overrun    <= 1'b0;
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            if (state == IDLE && state_d == LATCH) begin
                addr_q <= ioctl_addr;
                data_q <= ioctl_dout;
            end

            // Strobe is launched at the end of LATCH so it is visible in the DECODE cycle.
            if (state == LATCH) begin
                hit_q <= any_hit;
                if (any_hit) begin
                    bram_wr   <= 1'b1;
                    bram_cs   <= sel_oh;
                    bram_addr <= sel_off;
                    bram_data <= data_q;
                    hold_cnt  <= 8'(WR_HOLD);
                    byte_cnt  <= byte_cnt + 26'd1;
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
                    checksum  <= checksum + {8'h00, data_q};
`endif
                end
            end else if (bram_wr) begin
                if (hold_cnt == 8'd1) begin
                    bram_wr <= 1'b0;
                    bram_cs <= '0;
                end
                hold_cnt <= hold_cnt - 8'd1;
            end

            if (ioctl_wr && busy) overrun <= 1'b1;

            if (state != DONE && state_d == DONE) rom_loaded <= (byte_cnt != '0);

            if (state == DONE && state_d == IDLE) begin
                rom_loaded <= 1'b0;
                overrun    <= 1'b0;
                byte_cnt   <= '0;
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
                checksum   <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_xsleena_rom_loader.sv
// Directed bench for xsleena_rom_loader: two 32 KiB regions, WR_HOLD=2, strobe scoreboard on bram_wr rising edges.
module tb_xsleena_rom_loader;

    localparam logic [49:0] BASES = {25'h0008000, 25'h0000000};
    localparam logic [9:0]  LOGS  = {5'd15, 5'd15};
    localparam int          W     = 30;

    logic        clk = 1'b0;
    logic        RESETn;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        bram_wr;
    logic [7:0]  bram_data;
    logic [19:0] bram_addr;
    logic [1:0]  bram_cs;
    logic        rom_loaded;
    logic        overrun;
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int busy_cnt;
    logic wr_prev = 1'b0;
    logic [W-1:0] exp_q[$];

    xsleena_rom_loader #(
        .NUM_REGIONS(2),
        .REGION_BASE(BASES),
        .REGION_LOG2(LOGS),
        .ROM_INDEX(8'd0),
        .WR_HOLD(2)
    ) dut (
        .clk(clk),
        .RESETn(RESETn),
        .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait),
        .bram_wr(bram_wr),
        .bram_data(bram_data),
        .bram_addr(bram_addr),
        .bram_cs(bram_cs),
        .rom_loaded(rom_loaded),
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
        .checksum(checksum),
`endif
        .overrun(overrun)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every strobe launch must match the head of exp_q
    always @(negedge clk) begin
        if (bram_wr && !wr_prev) begin
            if (exp_q.size() == 0) check("sb_unexpected_write", 32'(exp_q.size()), 32'd1);
            else check("sb_write", 32'({bram_cs, bram_addr, bram_data}), 32'(exp_q.pop_front()));
        end
        wr_prev = bram_wr;
    end

    // driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        while (ioctl_wait && n < 10) begin
            tick();
            n++;
        end
        if (ioctl_wait) check("idle_timeout", 32'(ioctl_wait), 32'd0);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
        wait_idle();
    endtask

    initial begin
        RESETn = 1'b0; ioctl_download = 1'b1; ioctl_index = 8'd0;
        ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = '0;
        repeat (3) tick();
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_bram_wr", 32'(bram_wr), 32'd0);
        check("rst_bram_cs", 32'(bram_cs), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_bram_data", 32'(bram_data), 32'd0);
        check("rst_rom_loaded", 32'(rom_loaded), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif
        RESETn = 1'b1;
        tick(); tick();

        // single byte into region 1, cycle by cycle
        exp_q.push_back({2'b10, 20'h00010, 8'hA5});
        ioctl_wr = 1'b1; ioctl_addr = 25'h0008010; ioctl_dout = 8'hA5;
        tick();
        ioctl_wr = 1'b0;
        check("latch_wait", 32'(ioctl_wait), 32'd1);
        check("latch_bram_wr", 32'(bram_wr), 32'd0);
        tick();
        check("dec_bram_wr", 32'(bram_wr), 32'd1);
        check("dec_bram_cs", 32'(bram_cs), 32'h2);
        check("dec_bram_addr", 32'(bram_addr), 32'h10);
        check("dec_bram_data", 32'(bram_data), 32'hA5);
        check("dec_wait", 32'(ioctl_wait), 32'd1);
        tick();
        check("hold_bram_wr", 32'(bram_wr), 32'd1);
        check("hold_wait", 32'(ioctl_wait), 32'd1);
        tick();
        check("rel_bram_wr", 32'(bram_wr), 32'd0);
        check("rel_bram_cs", 32'(bram_cs), 32'd0);
        check("rel_wait", 32'(ioctl_wait), 32'd1);
        check("rel_bram_addr", 32'(bram_addr), 32'h10);
        tick();
        check("idle_wait", 32'(ioctl_wait), 32'd0);

        // unmapped byte
        ioctl_wr = 1'b1; ioctl_addr = 25'h0010000; ioctl_dout = 8'h5A;
        tick();
        ioctl_wr = 1'b0;
        tick();
        check("unm_bram_wr", 32'(bram_wr), 32'd0);
        check("unm_wait", 32'(ioctl_wait), 32'd1);
        tick();
        check("unm_idle_wait", 32'(ioctl_wait), 32'd0);
        check("unm_bram_cs", 32'(bram_cs), 32'd0);

        // region edges
        exp_q.push_back({2'b01, 20'h07FFF, 8'h11});
        send_byte(25'h0007FFF, 8'h11);
        exp_q.push_back({2'b10, 20'h07FFF, 8'h22});
        send_byte(25'h000FFFF, 8'h22);
        exp_q.push_back({2'b10, 20'h00000, 8'h33});
        send_byte(25'h0008000, 8'h33);

        // overrun: second strobe during LATCH is dropped
        check("ovr_before", 32'(overrun), 32'd0);
        exp_q.push_back({2'b01, 20'h00005, 8'h3C});
        ioctl_wr = 1'b1; ioctl_addr = 25'h0000005; ioctl_dout = 8'h3C;
        tick();
        ioctl_addr = 25'h0000006; ioctl_dout = 8'h77;
        tick();
        ioctl_wr = 1'b0;
        check("ovr_set", 32'(overrun), 32'd1);
        wait_idle();
        repeat (3) tick();
        check("ovr_addr_kept", 32'(bram_addr), 32'h5);

        ioctl_download = 1'b0;
        tick(); tick();
        check("done_rom_loaded", 32'(rom_loaded), 32'd1);
        check("done_overrun_held", 32'(overrun), 32'd1);
        check("done_wait", 32'(ioctl_wait), 32'd0);

        // new session clears sticky flags
        ioctl_download = 1'b1;
        tick(); tick();
        check("new_rom_loaded", 32'(rom_loaded), 32'd0);
        check("new_overrun", 32'(overrun), 32'd0);

        // top of download space never wraps into a region
        send_byte(25'h1FFFFFF, 8'hEE);

`ifdef XSLEENA_ROM_LOADER_CHECKSUM_EN
        exp_q.push_back({2'b01, 20'h00100, 8'hFF});
        send_byte(25'h0000100, 8'hFF);
        exp_q.push_back({2'b01, 20'h00101, 8'h01});
        send_byte(25'h0000101, 8'h01);
        exp_q.push_back({2'b01, 20'h00102, 8'h10});
        send_byte(25'h0000102, 8'h10);
        check("checksum", 32'(checksum), 32'h0110);
        ioctl_download = 1'b0;
        tick(); tick();
        check("checksum_held", 32'(checksum), 32'h0110);
`endif

        // index filter
        RESETn = 1'b0; ioctl_download = 1'b0;
        tick();
        RESETn = 1'b1;
        tick(); tick();
        check("idx_pre_rom_loaded", 32'(rom_loaded), 32'd0);
        ioctl_index = 8'd1; ioctl_download = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(i + 8'h40);
            tick();
            if (ioctl_wait) busy_cnt++;
            ioctl_wr = 1'b0;
            tick();
            if (ioctl_wait) busy_cnt++;
        end
        check("idx_wait_cycles", 32'(busy_cnt), 32'd0);
        check("idx_overrun", 32'(overrun), 32'd0);
        ioctl_download = 1'b0;
        tick(); tick();
        check("idx_rom_loaded", 32'(rom_loaded), 32'd0);

        // async reset in the first WRITE cycle
        ioctl_index = 8'd0; ioctl_download = 1'b1;
        tick(); tick();
        exp_q.push_back({2'b01, 20'h00040, 8'h99});
        ioctl_wr = 1'b1; ioctl_addr = 25'h0000040; ioctl_dout = 8'h99;
        tick();
        ioctl_wr = 1'b0;
        tick(); tick();
        check("midrst_pre_bram_wr", 32'(bram_wr), 32'd1);
        check("midrst_pre_wait", 32'(ioctl_wait), 32'd1);
        RESETn = 1'b0;
        #1;
        check("midrst_bram_wr", 32'(bram_wr), 32'd0);
        check("midrst_bram_cs", 32'(bram_cs), 32'd0);
        check("midrst_wait", 32'(ioctl_wait), 32'd0);
        tick();
        RESETn = 1'b1;
        tick();

        check("sb_pending", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
